// File: rtl/myproject_mul_pipe_sat_if.sv
// Operand/result bus for myproject_mul_pipe_sat.
// The master drives clock enable, operands and input valid.
// The slave (the multiplier) returns the result, its valid and the saturation flag.
interface myproject_mul_pipe_sat_if #(
   parameter int unsigned din0_WIDTH = 33,
   parameter int unsigned din1_WIDTH = 9,
   parameter int unsigned dout_WIDTH = 32
);
   logic                  ce;
   logic                  in_vld;
   logic [din0_WIDTH-1:0] din0;
   logic [din1_WIDTH-1:0] din1;
   logic [dout_WIDTH-1:0] dout;
   logic                  out_vld;
   logic                  ovf;

   modport master (
      output ce, in_vld, din0, din1,
      input  dout, out_vld, ovf
   );

   modport slave (
      input  ce, in_vld, din0, din1,
      output dout, out_vld, ovf
   );
endinterface

// File: rtl/myproject_mul_pipe_sat.sv
// Pipelined signed multiplier with arithmetic post-shift and saturation.
// Stage 1 registers the full-width product, middle stages are plain delay
// registers, and the last stage registers the shifted/saturated result.
// A valid chain of NUM_STAGE flops runs alongside the data; ce freezes everything.
// Optional feature: define MUL_PIPE_SAT_ROUND_EN for round-half-up before the
// shift (sum formed one bit wider than the product so it cannot wrap);
// otherwise the shift truncates toward -inf. Latency is the same either way.
module myproject_mul_pipe_sat #(
   parameter int          ID         = 1,
   parameter int          NUM_STAGE  = 2,
   parameter int unsigned din0_WIDTH = 33,
   parameter int unsigned din1_WIDTH = 9,
   parameter int unsigned dout_WIDTH = 32,
   parameter int          SHIFT      = 6
) (
   input logic                     ap_clk,
   input logic                     ap_rst,
   myproject_mul_pipe_sat_if.slave bus
);

   // Product width, rounded/shifted value width, and comparison width.
   localparam int unsigned PW = din0_WIDTH + din1_WIDTH;
   localparam int unsigned SW = PW + 1;
   localparam int unsigned CW = ((SW > dout_WIDTH) ? SW : dout_WIDTH) + 1;

   localparam logic signed [CW-1:0] MAXV =
      $signed({{(CW - dout_WIDTH + 1){1'b0}}, {(dout_WIDTH - 1){1'b1}}});
   localparam logic signed [CW-1:0] MINV =
      $signed({{(CW - dout_WIDTH + 1){1'b1}}, {(dout_WIDTH - 1){1'b0}}});

   // Reject configurations that cannot be built.
   if (NUM_STAGE < 1 || SHIFT < 0 || SHIFT >= int'(PW) || ID < 0) begin : g_bad_cfg
      $error("myproject_mul_pipe_sat: illegal NUM_STAGE/SHIFT/ID");
   end

   logic signed [PW-1:0]         w_prod;
   logic signed [PW-1:0]         w_p_last;
   logic signed [SW-1:0]         w_ext;
   logic signed [SW-1:0]         w_sum;
   logic signed [SW-1:0]         w_s;
   logic signed [CW-1:0]         w_sc;
   logic        [dout_WIDTH-1:0] w_dout;
   logic                         w_ovf;

   logic        [NUM_STAGE-1:0]  r_vld;
   logic        [dout_WIDTH-1:0] r_dout;
   logic                         r_ovf;

   // Full-precision signed product; no bits are dropped.
   assign w_prod = PW'($signed(bus.din0)) * PW'($signed(bus.din1));

   if (NUM_STAGE == 1) begin : g_single
      assign w_p_last = w_prod;
   end else begin : g_multi
      logic signed [PW-1:0] r_p [NUM_STAGE-1];

      // Product register followed by retiming delay registers.
      always_ff @(posedge ap_clk) begin
         if (ap_rst) begin
            for (int i = 0; i < NUM_STAGE - 1; i++) r_p[i] <= '0;
         end else if (bus.ce) begin
            r_p[0] <= w_prod;
            for (int i = 1; i < NUM_STAGE - 1; i++) r_p[i] <= r_p[i-1];
         end
      end

      assign w_p_last = r_p[NUM_STAGE-2];
   end

   assign w_ext = {w_p_last[PW-1], w_p_last};

`ifdef MUL_PIPE_SAT_ROUND_EN
   localparam logic signed [SW-1:0] RND =
      (SHIFT == 0) ? '0 : SW'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0);
   assign w_sum = w_ext + RND;
`else
   assign w_sum = w_ext;
`endif

   assign w_s  = w_sum >>> SHIFT;
   assign w_sc = CW'(w_s);

   // Clamp the shifted value to the signed output range and flag it.
   always_comb begin
      w_dout = w_sc[dout_WIDTH-1:0];
      w_ovf  = 1'b0;
      if (w_sc > MAXV) begin
         w_dout = MAXV[dout_WIDTH-1:0];
         w_ovf  = 1'b1;
      end else if (w_sc < MINV) begin
         w_dout = MINV[dout_WIDTH-1:0];
         w_ovf  = 1'b1;
      end
   end

   // Final stage: registered result and per-sample overflow flag.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_dout <= '0;
         r_ovf  <= 1'b0;
      end else if (bus.ce) begin
         r_dout <= w_dout;
         r_ovf  <= w_ovf;
      end
   end

   // Valid shift chain; its tail marks the sample leaving the last stage.
   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_vld <= '0;
      end else if (bus.ce) begin
         r_vld[0] <= bus.in_vld;
         for (int i = 1; i < NUM_STAGE; i++) r_vld[i] <= r_vld[i-1];
      end
   end

   assign bus.dout    = r_dout;
   assign bus.ovf     = r_ovf;
   assign bus.out_vld = r_vld[NUM_STAGE-1];

endmodule

// File: tb/tb_myproject_mul_pipe_sat.sv
// Scoreboard bench for myproject_mul_pipe_sat: two instances (3 stages/shift 6
// and 1 stage/shift 0) share one stimulus stream; a longint reference model
// predicts each result and the due ce-cycle at which it must appear.
module tb_myproject_mul_pipe_sat;

   localparam int W0 = 33;
   localparam int W1 = 9;
   localparam int WO = 32;
   localparam int NA = 3;
   localparam int SA = 6;
   localparam int NB = 1;
   localparam int SB = 0;

   typedef struct {
      longint      due;
      logic [31:0] dout;
      logic        ovf;
   } exp_t;

   logic   ap_clk = 1'b0;
   logic   ap_rst;
   exp_t   q_a[$];
   exp_t   q_b[$];
   longint cnt = 0;
   int     n_checks = 0;
   int     n_pass = 0;

   myproject_mul_pipe_sat_if #(.din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(WO)) bus_a ();
   myproject_mul_pipe_sat_if #(.din0_WIDTH(W0), .din1_WIDTH(W1), .dout_WIDTH(WO)) bus_b ();

   myproject_mul_pipe_sat #(.ID(1), .NUM_STAGE(NA), .din0_WIDTH(W0), .din1_WIDTH(W1),
                            .dout_WIDTH(WO), .SHIFT(SA)) u_dut_a (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .bus    (bus_a)
   );

   myproject_mul_pipe_sat #(.ID(2), .NUM_STAGE(NB), .din0_WIDTH(W0), .din1_WIDTH(W1),
                            .dout_WIDTH(WO), .SHIFT(SB)) u_dut_b (
      .ap_clk (ap_clk),
      .ap_rst (ap_rst),
      .bus    (bus_b)
   );

   always #5 ap_clk = ~ap_clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference: exact integer product, optional round-half-up, floor shift, clamp.
   function automatic exp_t model(input logic [32:0] a, input logic [8:0] b, input int sh);
      longint p, s, mx, mn;
      exp_t   e;
      p = longint'($signed(a)) * longint'($signed(b));
`ifdef MUL_PIPE_SAT_ROUND_EN
      if (sh > 0) p = p + (longint'(1) << (sh - 1));
`endif
      s  = p >>> sh;
      mx = (longint'(1) <<< 31) - 1;
      mn = -(longint'(1) <<< 31);
      e.due = 0;
      if (s > mx) begin
         e.dout = 32'(mx); e.ovf = 1'b1;
      end else if (s < mn) begin
         e.dout = 32'(mn); e.ovf = 1'b1;
      end else begin
         e.dout = 32'(s);  e.ovf = 1'b0;
      end
      return e;
   endfunction

   task automatic drive(input bit ce, input bit vld, input logic [32:0] a,
                        input logic [8:0] b, input bit rst);
      exp_t e;
      @(negedge ap_clk);
      ap_rst       = rst;
      bus_a.ce     = ce;  bus_b.ce     = ce;
      bus_a.in_vld = vld; bus_b.in_vld = vld;
      bus_a.din0   = a;   bus_b.din0   = a;
      bus_a.din1   = b;   bus_b.din1   = b;
      if (ce && vld && !rst) begin
         e = model(a, b, SA); e.due = cnt + NA; q_a.push_back(e);
         e = model(a, b, SB); e.due = cnt + NB; q_b.push_back(e);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 33'(0), 9'(0), 1'b0);
   endtask

   function automatic logic [32:0] rand_a();
      case ($urandom_range(0, 5))
         0: return 33'h1_0000_0000;
         1: return 33'h0_FFFF_FFFF;
         2: return 33'($urandom_range(0, 200)) - 33'd100;
         default: return {1'($urandom_range(0, 1)), 32'($urandom)};
      endcase
   endfunction

   function automatic logic [8:0] rand_b();
      case ($urandom_range(0, 4))
         0: return 9'h100;
         1: return 9'h0FF;
         default: return 9'($urandom);
      endcase
   endfunction

   // Monitor: on every ce edge the output must match the due queue entry (or be
   // invalid); stalled cycles must hold; reset cycles must read zero.
   logic        ce_q, rst_q, exp_vld;
   logic [33:0] prev_a, prev_b;
   exp_t        e_m;

   always begin
      @(posedge ap_clk);
      ce_q  = bus_a.ce;
      rst_q = ap_rst;
      if (rst_q) begin
         q_a.delete();
         q_b.delete();
      end else if (ce_q) begin
         cnt++;
      end
      #1;
      if (rst_q) begin
         check("rst_a", 64'({bus_a.out_vld, bus_a.ovf, bus_a.dout}), 64'(0));
         check("rst_b", 64'({bus_b.out_vld, bus_b.ovf, bus_b.dout}), 64'(0));
      end else if (ce_q) begin
         exp_vld = (q_a.size() > 0) && (q_a[0].due == cnt);
         check("vld_a", 64'(bus_a.out_vld), 64'(exp_vld));
         if (exp_vld) begin
            e_m = q_a.pop_front();
            check("dout_a", 64'(bus_a.dout), 64'(e_m.dout));
            check("ovf_a", 64'(bus_a.ovf), 64'(e_m.ovf));
         end
         exp_vld = (q_b.size() > 0) && (q_b[0].due == cnt);
         check("vld_b", 64'(bus_b.out_vld), 64'(exp_vld));
         if (exp_vld) begin
            e_m = q_b.pop_front();
            check("dout_b", 64'(bus_b.dout), 64'(e_m.dout));
            check("ovf_b", 64'(bus_b.ovf), 64'(e_m.ovf));
         end
      end else begin
         check("hold_a", 64'({bus_a.out_vld, bus_a.ovf, bus_a.dout}), 64'(prev_a));
         check("hold_b", 64'({bus_b.out_vld, bus_b.ovf, bus_b.dout}), 64'(prev_b));
      end
      prev_a = {bus_a.out_vld, bus_a.ovf, bus_a.dout};
      prev_b = {bus_b.out_vld, bus_b.ovf, bus_b.dout};
   end

   initial begin
      ap_rst       = 1'b1;
      bus_a.ce     = 1'b0; bus_b.ce     = 1'b0;
      bus_a.in_vld = 1'b0; bus_b.in_vld = 1'b0;
      bus_a.din0   = '0;   bus_b.din0   = '0;
      bus_a.din1   = '0;   bus_b.din1   = '0;
      drive(1'b0, 1'b0, 33'(0), 9'(0), 1'b1);
      drive(1'b1, 1'b1, 33'(5), 9'(5), 1'b1);

      // Latency: single pulse, then idle
      drive(1'b1, 1'b1, 33'(100), 9'(1), 1'b0);
      idle(5);

      // Sign handling
      drive(1'b1, 1'b1, 33'(1000), 9'(-3), 1'b0);
      drive(1'b1, 1'b1, 33'(-64), 9'(1), 1'b0);
      idle(4);

      // Saturation corners
      drive(1'b1, 1'b1, 33'h0_FFFF_FFFF, 9'h0FF, 1'b0);
      drive(1'b1, 1'b1, 33'h1_0000_0000, 9'h0FF, 1'b0);
      drive(1'b1, 1'b1, 33'h1_0000_0000, 9'h100, 1'b0);
      idle(4);

      // Stall mid-stream: 8 samples with a 5-cycle ce=0 window
      for (int i = 0; i < 8; i++) begin
         if (i == 4)
            for (int k = 0; k < 5; k++)
               drive(1'b0, 1'($urandom_range(0, 1)), rand_a(), rand_b(), 1'b0);
         drive(1'b1, 1'b1, rand_a(), rand_b(), 1'b0);
      end
      idle(4);

      // Reset with two samples in flight and ce low
      drive(1'b1, 1'b1, 33'(777), 9'(77), 1'b0);
      drive(1'b1, 1'b1, 33'(-555), 9'(55), 1'b0);
      drive(1'b0, 1'b1, 33'(1), 9'(1), 1'b1);
      drive(1'b1, 1'b1, 33'(12345), 9'(-7), 1'b0);
      idle(5);

      // Random operands, ce patterns and occasional reset
      for (int i = 0; i < 4000; i++)
         drive(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 7),
               rand_a(), rand_b(), 1'($urandom_range(0, 299) == 0));
      idle(NA + 3);

      check("drain_a", 64'(q_a.size()), 64'(0));
      check("drain_b", 64'(q_b.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
